uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLK_DIV, default 326, sysclk cycles per 16x-oversample tick (50 MHz / 9600 baud / 16).
REQ-002 Parameter DEPTH, default 4, number of FIFO entries; SHALL be a power of two, minimum 2.
REQ-003 sysclk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low; low forces every register to its reset value.
REQ-005 UART_RX  in  1  serial line, idle high, 8N1 frame, LSB first.
REQ-006 rd_en  in  1  pop request, one byte per cycle it is high.
REQ-007 clr_err  in  1  clears frame_err and overrun.
REQ-008 rd_data  out  8  head-of-FIFO byte (first-word-fall-through).
REQ-009 rx_valid  out  1  FIFO non-empty.
REQ-010 count  out  $clog2(DEPTH)+1  number of stored bytes.
REQ-011 frame_err  out  1  sticky, bad stop bit seen.
REQ-012 overrun  out  1  sticky, byte dropped because FIFO was full.

Function
REQ-013 UART_RX SHALL pass through a 2-flop synchronizer (both flops reset to 1); all sampling uses the synchronizer output rx_s.
REQ-014 Tick divider SHALL count 0..CLK_DIV-1 and wrap; tick = 1 for one cycle when the divider equals CLK_DIV-1; the divider runs freely, including in IDLE.
REQ-015 FSM states: IDLE, START, DATA, STOP; the bit-phase counter ph (0..15) and the bit index bi (0..7) advance only on tick.
REQ-016 IDLE: on tick with rx_s = 0 -> START, ph = 0.
REQ-017 Each bit value SHALL be the majority of rx_s sampled at ticks ph = 7, 8, 9; the decision is taken at ph = 9.
REQ-018 START: decision 1 (false start) -> IDLE; decision 0 -> continue to ph = 15, then DATA with bi = 0, ph = 0.
REQ-019 DATA: decided bit shifts into bit bi; at ph = 15, bi = 7 -> STOP, otherwise bi += 1.
REQ-020 STOP: decision 1 -> push the byte; decision 0 -> set frame_err and discard the byte; both cases -> IDLE in the same cycle (ph = 9), so back-to-back frames are accepted.
REQ-021 Push when full without a same-cycle pop: byte dropped, overrun set, FIFO unchanged.
REQ-022 Pop: rd_en with rx_valid = 1 advances the read pointer; rd_en with rx_valid = 0 is ignored, with no error.
REQ-023 Simultaneous push and pop: both are performed and count is unchanged; when full, this case is not an overrun.
REQ-024 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-025 rd_data SHALL equal mem[rptr] combinationally when count > 0, and 8'h00 when count = 0.
REQ-026 A set event SHALL take priority over clr_err in the same cycle.
REQ-027 A pushed byte SHALL appear on rd_data, with rx_valid = 1, in the cycle after the push edge.

Reset
REQ-028 After reset: FSM = IDLE; divider, ph, bi and shift register = 0; synchronizer = 1; pointers and count = 0; rx_valid = 0; rd_data = 8'h00; frame_err = 0; overrun = 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no partial push; after release, reception restarts only on a new falling edge seen in IDLE.
REQ-030 FIFO memory contents need not be reset; rd_data is masked by REQ-025.

Verification (CLK_DIV = 4, so 64 sysclk per bit)
REQ-031 Send 0x55, valid stop -> rx_valid = 1, rd_data = 8'h55, count = 1, frame_err = 0.
REQ-032 Send 0xA3, then 0x0F back-to-back; pulse rd_en twice -> rd_data reads 8'hA3 then 8'h0F; count goes 2 -> 1 -> 0; rx_valid = 0 at the end.
REQ-033 Send 0x3C with stop bit = 0 -> frame_err = 1, count = 0; pulse clr_err -> frame_err = 0.
REQ-034 Send DEPTH+1 bytes (0x01..0x05) with no reads -> count = 4, overrun = 1; reads return 0x01..0x04.
REQ-035 Drive UART_RX low for 24 sysclk (under half a bit) -> FSM returns to IDLE; no push, no error flags.
REQ-036 Assert reset at bit 4 of a frame, release, then send 0x7E -> only 8'h7E is stored, count = 1.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Host-side bundle of the UART receiver: serial input, pop/clear controls,
// and the FIFO head and status outputs.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          UART_RX;
    logic          rd_en;
    logic          clr_err;
    logic [7:0]    rd_data;
    logic          rx_valid;
    logic [CW-1:0] count;
    logic          frame_err;
    logic          overrun;

    modport master (
        output UART_RX, rd_en, clr_err,
        input  rd_data, rx_valid, count, frame_err, overrun
    );

    modport slave (
        input  UART_RX, rd_en, clr_err,
        output rd_data, rx_valid, count, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority voting,
// feeding a first-word-fall-through FIFO with sticky frame/overrun flags.
module uart_rx_fifo #(
    parameter int CLK_DIV = 326,
    parameter int DEPTH   = 4
) (
    input  logic         sysclk,
    input  logic         reset,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_meta_d;
    logic          rx_s_q, rx_s_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    ph_q, ph_d;
    logic [2:0]    bi_q, bi_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    smp_q, smp_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    mem_q [DEPTH];

    logic tick;
    logic vote;
    logic push;
    logic set_fe;
    logic full;
    logic empty;
    logic pop;
    logic do_push;
    logic set_ov;

    // Majority of the samples taken at ph 7 and 8 plus the live sample at ph 9.
    assign vote = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_s_q) | (smp_q[0] & rx_s_q);
    assign tick = (div_q == DIV_MAX);

    always_comb begin
        rx_meta_d = bus.UART_RX;
        rx_s_d    = rx_meta_q;
        div_d     = tick ? '0 : div_q + 1'b1;
        state_d   = state_q;
        ph_d      = ph_q;
        bi_d      = bi_q;
        shift_d   = shift_q;
        smp_d     = smp_q;
        push      = 1'b0;
        set_fe    = 1'b0;

        if (tick) begin
            if (ph_q == 4'd7) smp_d[1] = rx_s_q;
            if (ph_q == 4'd8) smp_d[0] = rx_s_q;
            if (state_q != IDLE) ph_d = ph_q + 4'd1;

            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d = START;
                        ph_d    = 4'd0;
                    end
                end
                START: begin
                    if (ph_q == 4'd9 && vote) begin
                        state_d = IDLE;
                    end else if (ph_q == 4'd15) begin
                        state_d = DATA;
                        bi_d    = 3'd0;
                    end
                end
                DATA: begin
                    if (ph_q == 4'd9) shift_d[bi_q] = vote;
                    if (ph_q == 4'd15) begin
                        if (bi_q == 3'd7) state_d = STOP;
                        else              bi_d    = bi_q + 3'd1;
                    end
                end
                STOP: begin
                    // Leave at mid-stop-bit so a start bit right behind is not missed.
                    if (ph_q == 4'd9) begin
                        state_d = IDLE;
                        if (vote) push   = 1'b1;
                        else      set_fe = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign pop     = bus.rd_en && !empty;
    assign do_push = push && (!full || pop);
    assign set_ov  = push && full && !pop;

    always_comb begin
        wptr_d      = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d      = pop ? rptr_q + 1'b1 : rptr_q;
        count_d     = count_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        case ({do_push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (set_fe)           frame_err_d = 1'b1;
        else if (bus.clr_err) frame_err_d = 1'b0;
        if (set_ov)           overrun_d   = 1'b1;
        else if (bus.clr_err) overrun_d   = 1'b0;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            div_q       <= '0;
            state_q     <= IDLE;
            ph_q        <= '0;
            bi_q        <= '0;
            shift_q     <= '0;
            smp_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            div_q       <= div_d;
            state_q     <= state_d;
            ph_q        <= ph_d;
            bi_q        <= bi_d;
            shift_q     <= shift_d;
            smp_q       <= smp_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Storage is left unreset; the head output is masked while empty.
    always_ff @(posedge sysclk) begin
        if (do_push) mem_q[wptr_q] <= shift_q;
    end

    assign bus.rd_data   = empty ? 8'h00 : mem_q[rptr_q];
    assign bus.rx_valid  = !empty;
    assign bus.count     = count_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule
